// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester ports and the data-memory command/response wires.
// The arbiter uses the slave view; requesters plus memory use the master view.
interface dmem_arbiter_if;
  logic        req0_valid;
  logic        req0_write;
  logic [31:0] req0_addr;
  logic [31:0] req0_wdata;
  logic        req0_ready;
  logic        req1_valid;
  logic        req1_write;
  logic [31:0] req1_addr;
  logic [31:0] req1_wdata;
  logic        req1_ready;
  logic        resp0_valid;
  logic [31:0] resp0_rdata;
  logic        resp1_valid;
  logic [31:0] resp1_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_dout;
  logic        busy;

  modport slave (
    input  req0_valid, req0_write, req0_addr, req0_wdata,
    input  req1_valid, req1_write, req1_addr, req1_wdata,
    input  mem_dout,
    output req0_ready, req1_ready,
    output resp0_valid, resp0_rdata, resp1_valid, resp1_rdata,
    output mem_addr, mem_din, mem_read, mem_write, busy
  );

  modport master (
    output req0_valid, req0_write, req0_addr, req0_wdata,
    output req1_valid, req1_write, req1_addr, req1_wdata,
    output mem_dout,
    input  req0_ready, req1_ready,
    input  resp0_valid, resp0_rdata, resp1_valid, resp1_rdata,
    input  mem_addr, mem_din, mem_read, mem_write, busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-ported data memory between two
// requesters; one transaction at a time, IDLE -> ACCESS -> RESP.
module dmem_arbiter #(
  parameter int unsigned MEM_LATENCY = 1
) (
  input logic           clk_i,
  input logic           reset_i,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

  state_t      state_q, state_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        owner_q, owner_d;
  logic        last_grant_q, last_grant_d;
  logic [3:0]  cnt_q, cnt_d;

  logic grant_s;
  logic accept_s;
  logic final_s;
  logic in_access_s;
  logic in_resp_s;

  // Grant selection: on a tie the port that did not win last time goes next.
  always_comb begin
    grant_s = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_s = ~last_grant_q;
    end else if (bus.req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  assign accept_s    = !reset_i && (state_q == IDLE) && (bus.req0_valid || bus.req1_valid);
  assign final_s     = (cnt_q == 4'd0);
  assign in_access_s = !reset_i && (state_q == ACCESS);
  assign in_resp_s   = !reset_i && (state_q == RESP);

  // Next-state and latch logic for the transaction sequencer.
  always_comb begin
    state_d      = state_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          wr_d         = grant_s ? bus.req1_write : bus.req0_write;
          addr_d       = grant_s ? bus.req1_addr  : bus.req0_addr;
          wdata_d      = grant_s ? bus.req1_wdata : bus.req0_wdata;
          owner_d      = grant_s;
          last_grant_d = grant_s;
          cnt_d        = CNT_INIT;
          state_d      = ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (final_s) begin
          // Stores report zero read data; loads sample memory on the last cycle.
          rdata_d = wr_q ? 32'h0000_0000 : bus.mem_dout;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      wr_q         <= 1'b0;
      addr_q       <= 32'h0000_0000;
      wdata_q      <= 32'h0000_0000;
      rdata_q      <= 32'h0000_0000;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= 4'd0;
    end else begin
      state_q      <= state_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

  // Output decode; everything is gated off while reset is high.
  always_comb begin
    bus.req0_ready  = accept_s && !grant_s;
    bus.req1_ready  = accept_s && grant_s;
    bus.mem_addr    = in_access_s ? addr_q  : 32'h0000_0000;
    bus.mem_din     = in_access_s ? wdata_q : 32'h0000_0000;
    bus.mem_read    = in_access_s && !wr_q;
    bus.mem_write   = in_access_s && wr_q && final_s;
    bus.resp0_valid = in_resp_s && !owner_q;
    bus.resp1_valid = in_resp_s && owner_q;
    bus.resp0_rdata = (in_resp_s && !owner_q) ? rdata_q : 32'h0000_0000;
    bus.resp1_rdata = (in_resp_s && owner_q)  ? rdata_q : 32'h0000_0000;
    bus.busy        = !reset_i && (state_q != IDLE);
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench: two arbiter instances (latency 1 and 4), each with a
// behavioural memory; responses are checked by independent monitors.
module tb_dmem_arbiter;

  typedef struct packed {
    logic        port;
    logic [31:0] data;
  } exp_t;

  logic clk;
  logic rst;

  dmem_arbiter_if ifa ();
  dmem_arbiter_if ifb ();

  dmem_arbiter #(.MEM_LATENCY(1)) dut_a (.clk_i(clk), .reset_i(rst), .bus(ifa));
  dmem_arbiter #(.MEM_LATENCY(4)) dut_b (.clk_i(clk), .reset_i(rst), .bus(ifb));

  logic [31:0] mem_a [0:1023];
  logic [31:0] mem_b [0:1023];
  logic        pre_en;
  logic        pre_sel;
  logic [9:0]  pre_idx;
  logic [31:0] pre_dat;

  exp_t exp_a[$];
  exp_t exp_b[$];
  exp_t e_a;
  exp_t e_b;
  logic grant_log[$];

  int n_chk;
  int n_pass;
  int wr_a, rd_a, wr_b, rd_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ifa.mem_dout = mem_a[ifa.mem_addr[11:2]];
  assign ifb.mem_dout = mem_b[ifb.mem_addr[11:2]];

  always @(posedge clk) begin
    if (pre_en && !pre_sel) mem_a[pre_idx] <= pre_dat;
    else if (ifa.mem_write) mem_a[ifa.mem_addr[11:2]] <= ifa.mem_din;
    if (pre_en && pre_sel) mem_b[pre_idx] <= pre_dat;
    else if (ifb.mem_write) mem_b[ifb.mem_addr[11:2]] <= ifb.mem_din;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (ifa.mem_write) wr_a++;
    if (ifa.mem_read)  rd_a++;
    if (ifb.mem_write) wr_b++;
    if (ifb.mem_read)  rd_b++;
  end

  // Monitors: pop and compare on every response pulse
  always @(negedge clk) begin
    if (ifa.resp0_valid || ifa.resp1_valid) begin
      if (exp_a.size() == 0) begin
        chk("a_resp_unexpected", 32'd1, 32'd0);
      end else begin
        e_a = exp_a.pop_front();
        chk("a_resp_onehot", {31'd0, ifa.resp0_valid & ifa.resp1_valid}, 32'd0);
        chk("a_resp_port", {31'd0, ifa.resp1_valid}, {31'd0, e_a.port});
        chk("a_resp_rdata", e_a.port ? ifa.resp1_rdata : ifa.resp0_rdata, e_a.data);
        chk("a_resp_other", e_a.port ? ifa.resp0_rdata : ifa.resp1_rdata, 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (ifb.resp0_valid || ifb.resp1_valid) begin
      if (exp_b.size() == 0) begin
        chk("b_resp_unexpected", 32'd1, 32'd0);
      end else begin
        e_b = exp_b.pop_front();
        chk("b_resp_onehot", {31'd0, ifb.resp0_valid & ifb.resp1_valid}, 32'd0);
        chk("b_resp_port", {31'd0, ifb.resp1_valid}, {31'd0, e_b.port});
        chk("b_resp_rdata", e_b.port ? ifb.resp1_rdata : ifb.resp0_rdata, e_b.data);
        chk("b_resp_other", e_b.port ? ifb.resp0_rdata : ifb.resp1_rdata, 32'd0);
      end
    end
  end

  task automatic set_a(input bit p, input bit v, input bit w, input logic [31:0] ad, input logic [31:0] wd);
    if (p) begin
      ifa.req1_valid = v; ifa.req1_write = w; ifa.req1_addr = ad; ifa.req1_wdata = wd;
    end else begin
      ifa.req0_valid = v; ifa.req0_write = w; ifa.req0_addr = ad; ifa.req0_wdata = wd;
    end
  endtask

  task automatic set_b(input bit p, input bit v, input bit w, input logic [31:0] ad, input logic [31:0] wd);
    if (p) begin
      ifb.req1_valid = v; ifb.req1_write = w; ifb.req1_addr = ad; ifb.req1_wdata = wd;
    end else begin
      ifb.req0_valid = v; ifb.req0_write = w; ifb.req0_addr = ad; ifb.req0_wdata = wd;
    end
  endtask

  function automatic logic rdy_a(input bit p);
    return p ? ifa.req1_ready : ifa.req0_ready;
  endfunction

  // Issue one request on DUT A; called right after a falling edge.
  task automatic drv_a(input bit p, input bit w, input logic [31:0] ad, input logic [31:0] wd,
                       input logic [31:0] ex);
    int n;
    exp_t e;
    n = 0;
    set_a(p, 1'b1, w, ad, wd);
    #1;
    while (!rdy_a(p) && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (rdy_a(p)) begin
      e.port = p;
      e.data = ex;
      exp_a.push_back(e);
      grant_log.push_back(p);
    end else begin
      chk("a_ready_timeout", 32'd0, 32'd1);
    end
    @(posedge clk);
    #1;
    set_a(p, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic drain(input bit which);
    int n;
    n = 0;
    while (((which ? exp_b.size() : exp_a.size()) != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(which ? "b_drain" : "a_drain", which ? exp_b.size() : exp_a.size(), 32'd0);
  endtask

  task automatic preset(input bit sel, input int idx, input logic [31:0] d);
    pre_sel = sel;
    pre_idx = 10'(idx);
    pre_dat = d;
    pre_en  = 1'b1;
    @(posedge clk);
    #1;
    pre_en = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int s_wr, s_rd;
    exp_t e;
    n_chk = 0; n_pass = 0;
    wr_a = 0; rd_a = 0; wr_b = 0; rd_b = 0;
    pre_en = 1'b0; pre_sel = 1'b0; pre_idx = 10'd0; pre_dat = 32'd0;
    rst = 1'b1;
    set_a(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_a(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    set_b(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_b(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    ifa.req0_valid = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) preset(1'b0, 16 + i, 32'h1111_0000 + 32'(i));
    preset(1'b0, 24, 32'h5A5A_5A5A);
    preset(1'b0, 26, 32'h1357_9BDF);
    preset(1'b1, 8,  32'h1234_5678);
    preset(1'b1, 12, 32'hAAAA_5555);

    // Reset holds combinational outputs low even with a valid request
    chk("rst_ready0", {31'd0, ifa.req0_ready}, 32'd0);
    chk("rst_busy", {31'd0, ifa.busy}, 32'd0);
    chk("rst_memrd", {31'd0, ifa.mem_read}, 32'd0);
    ifa.req0_valid = 1'b0;
    rst = 1'b0;

    // Idle bus on both instances
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_a", {ifa.mem_addr[29:0], ifa.mem_read | ifa.mem_write, ifa.busy | ifa.resp0_valid | ifa.resp1_valid}, 32'd0);
      chk("idle_b", {ifb.mem_addr[29:0], ifb.mem_read | ifb.mem_write, ifb.busy | ifb.resp0_valid | ifb.resp1_valid}, 32'd0);
    end

    // Store 0xDEADBEEF to 0x10 with exact cycle timing
    set_a(1'b0, 1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    #1;
    chk("st_ready0_T", {31'd0, ifa.req0_ready}, 32'd1);
    chk("st_ready1_T", {31'd0, ifa.req1_ready}, 32'd0);
    e.port = 1'b0; e.data = 32'd0; exp_a.push_back(e);
    @(posedge clk); #1;
    set_a(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    chk("st_memwr_T1", {31'd0, ifa.mem_write}, 32'd1);
    chk("st_addr_T1", ifa.mem_addr, 32'h0000_0010);
    chk("st_din_T1", ifa.mem_din, 32'hDEAD_BEEF);
    chk("st_memrd_T1", {31'd0, ifa.mem_read}, 32'd0);
    @(negedge clk);
    chk("st_resp_T2", {31'd0, ifa.resp0_valid}, 32'd1);
    chk("st_memwr_T2", {31'd0, ifa.mem_write}, 32'd0);
    chk("st_mem_word", mem_a[4], 32'hDEAD_BEEF);
    @(negedge clk);
    drv_a(1'b0, 1'b0, 32'h0000_0010, 32'd0, 32'hDEAD_BEEF);
    drain(1'b0);

    // Both ports valid from the first idle cycle after reset
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    grant_log.delete();
    fork
      begin
        for (int i = 0; i < 4; i++)
          drv_a(1'b0, 1'b0, 32'h40 + 32'(4 * i), 32'd0, 32'h1111_0000 + 32'(i));
      end
      begin
        for (int j = 0; j < 4; j++)
          drv_a(1'b1, 1'b1, 32'h80 + 32'(4 * j), 32'hCAFE_0000 + 32'(j), 32'd0);
      end
    join
    drain(1'b0);
    chk("alt_count", grant_log.size(), 32'd8);
    for (int i = 0; i < grant_log.size() && i < 8; i++)
      chk("alt_order", {31'd0, grant_log[i]}, 32'(i % 2));
    for (int i = 0; i < 4; i++)
      chk("alt_store", mem_a[32 + i], 32'hCAFE_0000 + 32'(i));

    // Port 0 arrives while port 1 is being served
    @(negedge clk);
    set_a(1'b1, 1'b1, 1'b0, 32'h60, 32'd0);
    #1;
    chk("bw_ready1_T", {31'd0, ifa.req1_ready}, 32'd1);
    e.port = 1'b1; e.data = 32'h5A5A_5A5A; exp_a.push_back(e);
    @(posedge clk); #1;
    set_a(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    set_a(1'b0, 1'b1, 1'b1, 32'h64, 32'h0000_0077);
    @(negedge clk); #1;
    chk("bw_ready0_T1", {31'd0, ifa.req0_ready}, 32'd0);
    @(negedge clk); #1;
    chk("bw_ready0_T2", {31'd0, ifa.req0_ready}, 32'd0);
    @(negedge clk); #1;
    chk("bw_ready0_T3", {31'd0, ifa.req0_ready}, 32'd1);
    e.port = 1'b0; e.data = 32'd0; exp_a.push_back(e);
    @(posedge clk); #1;
    set_a(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drain(1'b0);
    chk("bw_store", mem_a[25], 32'h0000_0077);

    // Request withdrawn before it is granted leaves no trace
    @(negedge clk);
    s_wr = wr_a; s_rd = rd_a;
    set_a(1'b1, 1'b1, 1'b0, 32'h60, 32'd0);
    e.port = 1'b1; e.data = 32'h5A5A_5A5A; exp_a.push_back(e);
    @(posedge clk); #1;
    set_a(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    set_a(1'b0, 1'b1, 1'b1, 32'h68, 32'h0000_0099);
    @(negedge clk);
    @(negedge clk);
    set_a(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drain(1'b0);
    repeat (3) @(negedge clk);
    chk("drop_writes", 32'(wr_a - s_wr), 32'd0);
    chk("drop_reads", 32'(rd_a - s_rd), 32'd1);
    chk("drop_word", mem_a[26], 32'h1357_9BDF);

    // Latency 4 load on port 1
    s_wr = wr_b;
    set_b(1'b1, 1'b1, 1'b0, 32'h20, 32'd0);
    #1;
    chk("l4_ready1_T", {31'd0, ifb.req1_ready}, 32'd1);
    e.port = 1'b1; e.data = 32'h1234_5678; exp_b.push_back(e);
    @(posedge clk); #1;
    set_b(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("l4_memrd", {31'd0, ifb.mem_read}, 32'd1);
      chk("l4_addr", ifb.mem_addr, 32'h20);
    end
    @(negedge clk);
    chk("l4_resp_T5", {31'd0, ifb.resp1_valid}, 32'd1);
    chk("l4_memrd_T5", {31'd0, ifb.mem_read}, 32'd0);
    drain(1'b1);
    chk("l4_no_write", 32'(wr_b - s_wr), 32'd0);

    // Latency 4 store abandoned by reset during its access window
    @(negedge clk);
    s_wr = wr_b;
    set_b(1'b0, 1'b1, 1'b1, 32'h30, 32'h0BAD_F00D);
    #1;
    chk("ab_ready0_T", {31'd0, ifb.req0_ready}, 32'd1);
    @(posedge clk); #1;
    set_b(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    chk("ab_busy_T1", {31'd0, ifb.busy}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("ab_memwr_rst", {31'd0, ifb.mem_write}, 32'd0);
    @(negedge clk);
    chk("ab_busy_rst", {31'd0, ifb.busy}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("ab_quiet", {ifb.mem_addr[29:0], ifb.mem_write | ifb.mem_read, ifb.busy | ifb.resp0_valid | ifb.resp1_valid}, 32'd0);
    end
    chk("ab_writes", 32'(wr_b - s_wr), 32'd0);
    chk("ab_word", mem_b[12], 32'hAAAA_5555);

    chk("end_queue_a", exp_a.size(), 32'd0);
    chk("end_queue_b", exp_b.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer that shares the single-ported `data_memory` between two requesters: port 0 (CPU load/store unit) and port 1 (secondary master, e.g. loader/debug DMA). It accepts one transaction at a time with round-robin fairness, drives the memory's `addr`/`din`/`mem_read`/`mem_write` for a configurable number of cycles, and returns a one-cycle response. It sits between the pipeline's MEM stage and `data_memory`.

## Interface
- `MEM_LATENCY`, 1: cycles the memory command is held per access; legal 1..15.

- `clk`  in  1  system clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high; clears all state
- `req0_valid`, `req1_valid`  in  1  requester i has a transaction
- `req0_write`, `req1_write`  in  1  1 = store, 0 = load
- `req0_addr`, `req1_addr`  in  32  byte address, passed unmodified
- `req0_wdata`, `req1_wdata`  in  32  store data
- `req0_ready`, `req1_ready`  out  1  transaction accepted this cycle (valid & ready)
- `resp0_valid`, `resp1_valid`  out  1  one-cycle completion pulse
- `resp0_rdata`, `resp1_rdata`  out  32  load data; 0 for stores
- `mem_addr`  out  32  to memory `addr`
- `mem_din`  out  32  to memory `din`
- `mem_read`  out  1  to memory `mem_read`
- `mem_write`  out  1  to memory `mem_write`
- `mem_dout`  in  32  from memory `dout` (combinational read)
- `busy`  out  1  state != IDLE

## Operation
- States: IDLE, ACCESS, RESP. Registers: state, latched write/addr/wdata, owner (1 bit), last_grant (1 bit), 4-bit countdown, 32-bit rdata.
- IDLE: grant = only valid port; if both valid, the port != last_grant. `reqN_ready` = (state==IDLE) & grant==N, combinational; at most one ready high per cycle. On valid&ready: latch write/addr/wdata, owner=N, last_grant=N, count=MEM_LATENCY-1, go ACCESS.
- ACCESS: `mem_addr`=latched addr, `mem_din`=latched wdata. Load: `mem_read`=1 every ACCESS cycle; on final cycle (count==0) capture `mem_dout` into rdata. Store: `mem_write`=1 only on final cycle (exactly one write per store); rdata=0. count decrements each non-final cycle; final cycle -> RESP.
- RESP: `resp<owner>_valid`=1, `resp<owner>_rdata`=rdata for one cycle; other port's resp outputs 0; -> IDLE.
- Outside ACCESS: `mem_read`=`mem_write`=0, `mem_addr`=`mem_din`=0. `respN_rdata`=0 whenever `respN_valid`=0.
- Requesters hold valid/write/addr/wdata stable until ready; dropping valid before ready is legal and has no effect. Inputs are ignored outside IDLE.
- Addresses are not checked or aligned; memory uses bits [15:2].

## Timing
- Accept at cycle T (edge end of T). ACCESS cycles T+1..T+MEM_LATENCY. `resp_valid` at T+MEM_LATENCY+1. Next accept earliest T+MEM_LATENCY+2.
- MEM_LATENCY=1: accept T, mem command T+1, resp T+2, next accept T+3; throughput one transaction per 3 cycles.
- Store takes effect at the rising edge ending the final ACCESS cycle; a load granted afterward to the same word returns new data.
- Reset: state=IDLE, last_grant=1 (port 0 wins first tie), rdata=0, count=0; all outputs 0 in the cycle following reset-high edge, and combinational outputs forced 0 while reset is high (no ready, no mem command).
- Reset mid-ACCESS/RESP: transaction abandoned, no response, store not performed unless its final-cycle edge already occurred before reset asserted. Reset dominates all other events.
- Both valid continuously: grants strictly alternate 0,1,0,1...
- Valid arriving while busy: waits; no grant until IDLE.

## Test plan
- Reset, then req0 store addr 0x10 data 0xDEADBEEF (L=1) -> ready0 at T, `mem_write`=1 with `mem_addr`=0x10 only at T+1, resp0_valid at T+2 with rdata 0; then req0 load 0x10 -> resp0_rdata=0xDEADBEEF.
- Both valid from first IDLE cycle after reset, four transactions each -> grant order 0,1,0,1,...; each response routed only to owner port.
- MEM_LATENCY=4, req1 load 0x20 preset to 0x12345678 -> `mem_read` high T+1..T+4, resp1_valid at T+5 with 0x12345678, `mem_write` never high.
- MEM_LATENCY=4 store, reset asserted at T+2 -> no `mem_write` pulse, no resp, memory word unchanged, all outputs 0 after reset.
- req0_valid raised at T+1 while req1 transaction busy -> ready0 held 0 until IDLE, then accepted; req valid dropped before ready -> no memory activity.
- Idle bus -> `mem_read`, `mem_write`, `mem_addr`, `busy` all 0 every cycle.
